conv_result_buffer: RTL and testbench

Downstream stage of the convolution engine. Captures every `output_valid` pixel from the output filter into a small FIFO and exposes it to the management SoC through a Wishbone slave. The SoC can drain results by polling or by taking an interrupt, without pacing the convolution pipeline. It also counts pixels per frame and flags FIFO overflow.

---
 rtl/conv_result_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_conv_result_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_buffer.sv
// conv_result_buffer: captures convolution output pixels in a FIFO and exposes them over Wishbone.
// Latency: a pixel is visible in STATUS one cycle after capture; Wishbone ack one cycle after request.
// Backpressure: none toward the pipeline; pixels arriving at a full FIFO are dropped and flagged.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   pixel_in, pixel_valid      signed pixel stream from the output filter
//   wbs_*                      Wishbone slave (cyc/stb/we/adr/dat in, ack/dat out)
//   irq                        level interrupt
//
// Build option: define CONV_RESULT_IRQ_EN to build the registered interrupt;
// otherwise irq is tied low and no interrupt logic exists.

// Generic synchronous FIFO with flush. The head entry is presented
// combinationally on dout. A push into a full FIFO is taken only when a pop
// happens in the same cycle.
module crb_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push & ~flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module conv_result_buffer #(
   parameter int BITS         = 9,
   parameter int DEPTH        = 16,
   parameter int FRAME_PIXELS = 196
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] pixel_in,
   input  logic            pixel_valid,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic            irq
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_t;

   reg_sel_t        sel;
   logic            req;
   logic            rd_req;
   logic            ctrl_wr;
   logic            pop;
   logic            push;
   logic            flush;
   logic            clr_ovf;
   logic            clr_fd;
   logic            ovf_set;
   logic            frame_wrap;
   logic [BITS-1:0] head;
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            overflow;
   logic            frame_done;
   logic [15:0]     pix_cnt;
   logic [31:0]     count_ext;
   logic [31:0]     status_word;
   logic [31:0]     rd_dat;
   logic            unused_bits;

   // Gating on ~ack turns a held cyc/stb into one request every other cycle.
   assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign sel     = reg_sel_t'(wbs_adr_i[3:2]);
   assign rd_req  = req & ~wbs_we_i;
   assign ctrl_wr = req & wbs_we_i & (sel == REG_CTRL);

   assign clr_ovf = ctrl_wr & wbs_dat_i[0];
   assign clr_fd  = ctrl_wr & wbs_dat_i[1];
   assign flush   = ctrl_wr & wbs_dat_i[2];

   // A DATA read pops at the same edge that raises ack.
   assign pop  = rd_req & (sel == REG_DATA) & ~empty;
   // A pop frees the slot, so a full FIFO still accepts a pixel that
   // arrives with a DATA read. Flush discards a concurrent pixel.
   assign push = pixel_valid & ~flush & (~full | pop);
   // Only a pixel lost to lack of space counts as overflow; one discarded
   // by a flush was deliberately thrown away.
   assign ovf_set    = pixel_valid & ~flush & full & ~pop;
   assign frame_wrap = pixel_valid & (pix_cnt == 16'(FRAME_PIXELS - 1));

   crb_fifo #(
      .W     (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (pixel_in),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // count is zero-extended; with DEPTH=256 a full FIFO reads 0 in [7:0]
   // and the full bit disambiguates.
   assign count_ext   = 32'(count);
   assign status_word = {pix_cnt, 4'b0000, frame_done, overflow, full, empty, count_ext[7:0]};

   always_comb begin
      rd_dat = '0;
      case (sel)
         REG_DATA: begin
            if (!empty) begin
               rd_dat = {{(32-BITS){head[BITS-1]}}, head};
            end
         end
         REG_STATUS: rd_dat = status_word;
         default:    rd_dat = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
         pix_cnt    <= '0;
      end else begin
         wbs_ack_o <= req;
         // Read data is held only for the ack cycle, zero otherwise.
         wbs_dat_o <= rd_req ? rd_dat : '0;

         // Set beats clear when both land in the same cycle.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end

         if (frame_wrap) begin
            frame_done <= 1'b1;
         end else if (clr_fd) begin
            frame_done <= 1'b0;
         end

         // Counts every pixel, accepted, dropped or flushed.
         if (pixel_valid) begin
            pix_cnt <= frame_wrap ? 16'd0 : pix_cnt + 16'd1;
         end
      end
   end

`ifdef CONV_RESULT_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= frame_done | overflow | (count >= CW'(DEPTH / 2));
      end
   end
`else
   assign irq = 1'b0;
`endif

   // Address and write-data bits outside the register map are ignored.
   assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:3]};
endmodule

// File: tb/tb_conv_result_buffer.sv
// Bench for conv_result_buffer: directed Wishbone/pixel stimulus with a
// scoreboard queue of expected read data and a negedge monitor.
// Clock period 10; inputs driven 1 time unit after the rising edge.
module tb_conv_result_buffer;
   localparam int BITS  = 9;
   localparam int DEPTH = 16;
   localparam int FRAME = 196;
`ifdef CONV_RESULT_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [BITS-1:0] pixel_in = '0;
   logic            pixel_valid = 1'b0;
   logic            wbs_cyc_i = 1'b0;
   logic            wbs_stb_i = 1'b0;
   logic            wbs_we_i = 1'b0;
   logic [31:0]     wbs_adr_i = '0;
   logic [31:0]     wbs_dat_i = '0;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic            irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   bit          chk_q[$];
   string       nm_q[$];

   conv_result_buffer #(
      .BITS(BITS), .DEPTH(DEPTH), .FRAME_PIXELS(FRAME)
   ) dut (
      .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
      .wbs_dat_o(wbs_dat_o), .irq(irq)
   );

   always #5 clk = ~clk;

   // Monitor: every ack consumes one scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack=1 with dat=%h, required no ack", wbs_dat_o);
            end else begin
               logic [31:0] e;
               bit          c;
               string       n;
               e = exp_q.pop_front();
               c = chk_q.pop_front();
               n = nm_q.pop_front();
               if (c) begin
                  checks++;
                  if (wbs_dat_o !== e) begin
                     errors++;
                     $display("FAIL %s: dat_o=%h required %h", n, wbs_dat_o, e);
                  end
               end
            end
         end
      end
   end

   task automatic check1(input string nm, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b", nm, got, req);
      end
   endtask

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   // One Wishbone transfer, optionally with a pixel in the request cycle.
   task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                     input bit chk, input logic [31:0] exp, input string nm,
                     input bit with_pix, input logic [BITS-1:0] pix);
      exp_q.push_back(exp);
      chk_q.push_back(chk);
      nm_q.push_back(nm);
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = wdat;
      if (with_pix) begin
         pixel_in    = pix;
         pixel_valid = 1'b1;
      end
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      check1({nm, "_ack_rise"}, wbs_ack_o, 1'b1);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      @(posedge clk); #1;
      check1({nm, "_ack_fall"}, wbs_ack_o, 1'b0);
   endtask

   task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
      wb(1'b0, adr, 32'h0, 1'b1, exp, nm, 1'b0, '0);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string nm);
      wb(1'b1, adr, dat, 1'b0, 32'h0, nm, 1'b0, '0);
   endtask

   task automatic push_pix(input logic [BITS-1:0] v);
      pixel_in    = v;
      pixel_valid = 1'b1;
      @(posedge clk); #1;
      pixel_valid = 1'b0;
   endtask

   localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_RSVD = 32'hC;

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check1("rst_ack", wbs_ack_o, 1'b0);
      check32("rst_dat", wbs_dat_o, 32'h0);
      check1("rst_irq", irq, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      rd(A_STAT, 32'h0000_0100, "stat_reset");

      // Held request is acked every other cycle.
      exp_q.push_back(32'h0000_0100); chk_q.push_back(1'b1); nm_q.push_back("b2b_0");
      exp_q.push_back(32'h0000_0100); chk_q.push_back(1'b1); nm_q.push_back("b2b_1");
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_STAT;
      @(posedge clk); #1; check1("b2b_ack0", wbs_ack_o, 1'b1);
      @(posedge clk); #1; check1("b2b_ack1", wbs_ack_o, 1'b0);
      @(posedge clk); #1; check1("b2b_ack2", wbs_ack_o, 1'b1);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(posedge clk); #1; check1("b2b_ack3", wbs_ack_o, 1'b0);

      // Three pixels with sign extension
      push_pix(9'd5);
      push_pix(9'h1FF);
      push_pix(9'h0FF);
      rd(A_STAT, 32'h0003_0003, "stat_3");
      rd(A_CTRL, 32'h0, "ctrl_rd_zero");
      rd(A_RSVD, 32'h0, "rsvd_rd_zero");
      wr(A_RSVD, 32'hFFFF_FFFF, "rsvd_wr");
      wr(A_DATA, 32'h55, "data_wr");
      rd(A_STAT, 32'h0003_0003, "stat_after_ignored_wr");
      rd(A_DATA, 32'h0000_0005, "data_5");
      rd(A_DATA, 32'hFFFF_FFFF, "data_m1");
      rd(A_DATA, 32'h0000_00FF, "data_255");
      rd(A_STAT, 32'h0003_0100, "stat_empty");
      rd(A_DATA, 32'h0, "data_empty");

      // Overflow: 18 pixels into 16 entries
      for (int i = 1; i <= 18; i++) push_pix(9'(i));
      rd(A_STAT, 32'h0015_0610, "stat_full_ovf");
      check1("irq_ovf", irq, IRQ_EN);
      // Read concurrent with a pixel while full: pixel accepted
      wb(1'b0, A_DATA, 32'h0, 1'b1, 32'd1, "data_pop_push", 1'b1, 9'd100);
      rd(A_STAT, 32'h0016_0610, "stat_still_full");
      wr(A_CTRL, 32'h1, "clr_ovf");
      rd(A_STAT, 32'h0016_0210, "stat_ovf_clr");
      for (int i = 2; i <= 16; i++) rd(A_DATA, 32'(i), "data_drain");
      rd(A_DATA, 32'd100, "data_100");
      rd(A_STAT, 32'h0016_0100, "stat_drained");
      check1("irq_idle", irq, 1'b0);

      // Finish the frame while draining: 22 pixels seen so far
      for (int i = 0; i < FRAME - 22; i++) begin
         push_pix(9'(i));
         rd(A_DATA, 32'(i), "data_stream");
      end
      rd(A_STAT, 32'h0000_0900, "stat_frame_done");
      check1("irq_frame", irq, IRQ_EN);
      for (int i = 10; i < 18; i++) push_pix(9'(i));
      rd(A_STAT, 32'h0008_0808, "stat_8_fd");
      wr(A_CTRL, 32'h2, "clr_fd");
      rd(A_STAT, 32'h0008_0008, "stat_fd_clr");
      check1("irq_half", irq, IRQ_EN);
      rd(A_DATA, 32'd10, "data_10");
      @(posedge clk); #1;
      check1("irq_below_half", irq, 1'b0);

      // Flush concurrent with a pixel: flush wins, pix_cnt still counts
      wb(1'b1, A_CTRL, 32'h4, 1'b0, 32'h0, "flush_pix", 1'b1, 9'd77);
      rd(A_STAT, 32'h0009_0100, "stat_flush");

      // Reset with a pending request and 5 pixels stored
      for (int i = 0; i < 5; i++) push_pix(9'(i + 40));
      rd(A_STAT, 32'h000E_0005, "stat_pre_reset");
      reset = 1'b1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
      @(posedge clk); #1;
      reset = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      check1("reset_no_ack", wbs_ack_o, 1'b0);
      check1("reset_irq", irq, 1'b0);
      @(posedge clk); #1;
      check1("reset_no_ack_late", wbs_ack_o, 1'b0);
      rd(A_STAT, 32'h0000_0100, "stat_post_reset");
      rd(A_DATA, 32'h0, "data_post_reset");

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end
endmodule
